display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexed scan controller for a 4-digit common-anode 7-segment display that shares one segment bus. It holds two 5-bit values (0–31) and converts each to tens/ones digits with two instances of the team's binary-to-two-digit 7-segment converter, `Display_GL`. It then scans the four digits in round-robin order. Value updates arrive over a valid/ready port and are applied only at frame boundaries, so a frame never shows a mix of old and new digits. The block sits between the processor's display output register and the board's display pins.

## Interface
- `PERIOD`, default 4: cycles each digit is driven; legal range ≥ 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `upd_val`  in  1  update request valid.
- `upd_sel`  in  1  target slot: 0 selects value 0, 1 selects value 1.
- `upd_data`  in  5  new value for the selected slot.
- `upd_rdy`  out  1  update port ready; a transfer occurs on a cycle where `upd_val && upd_rdy`.
- `seg`  out  7  active-low segments, bit order {g,f,e,d,c,b,a}, identical encoding to `Display_GL`.
- `an`  out  4  active-low digit enables; exactly one bit is low, or all are high when blanked.
- `frame`  out  1  high for one cycle on the first cycle of each frame.

## Operation
- **State:**
  - prescale counter `pc` (0..PERIOD-1)
  - digit index `d` (2 bits)
  - active registers `act0`, `act1` (5 bits each)
  - shadow registers `shd0`, `shd1` (5 bits each)
  - pending flags `pend[1:0]`
- **Digit map:**
  - d=0: `act0` ones, an=1110
  - d=1: `act0` tens, an=1101
  - d=2: `act1` ones, an=1011
  - d=3: `act1` tens, an=0111
- **Scan:**
  - `pc` increments every cycle.
  - At `pc==PERIOD-1`, `pc` wraps to 0 and `d` advances 0→1→2→3→0.
- **Frame boundary:** the cycle where `pc==PERIOD-1 && d==3`.
- **Update port:**
  - `upd_rdy = !pend[upd_sel]` (combinational).
  - An accepted transfer in a non-boundary cycle writes `shd[upd_sel]` and sets `pend[upd_sel]`.
- **At the boundary edge, for each slot:**
  - If a transfer is accepted this same cycle for the slot: `act <= upd_data`; the pending flag stays clear.
  - Otherwise, if `pend` is set: `act <= shd` and the flag clears.
  - Otherwise: `act` holds.
- **Outputs:** `seg`, `an` and `frame` are combinational from registered state only (`d`, `pc`, `act*`). There is no input-to-output path.
- `frame = (d==0 && pc==0)`.
- **Reset:** `pc=0`, `d=0`, `act*=0`, `shd*=0`, `pend=00`.
  - Outputs at reset: `an=1110`, `seg=100_0000`, `frame=1`, `upd_rdy=1`.
- **Reset mid-frame:** all state returns to reset values on the next edge. Pending updates are discarded.

## Timing
- Each digit is driven for exactly PERIOD cycles; a frame is 4·PERIOD cycles.
- **Update latency:** a transfer accepted at cycle t becomes visible on the first cycle of the next frame.
  - Worst case: 4·PERIOD cycles.
  - Best case: 1 cycle, when t is the boundary cycle.
- A second update to the same slot stalls (`upd_rdy=0`) until the boundary edge clears `pend`.
  - It can be accepted at the boundary cycle only if `pend` is already clear.
  - The two slots are independent.
- Simultaneous update to a pending slot at the boundary: `upd_rdy=0`, so no transfer occurs. The old shadow value is applied and the request is accepted on the following cycle.
- `upd_val` with `upd_rdy=0` changes no state. The requester must hold `upd_val`, `upd_sel` and `upd_data` stable until the transfer.

## Configuration
- **`DISPLAY_SCAN_LZS_EN` defined (leading-zero suppression):**
  - During d=1 with `act0<10`, or d=3 with `act1<10`: `an=1111` and `seg=111_1111`.
  - The slot still consumes PERIOD cycles.
- **Not defined:** the tens digit is always driven. A tens value of 0 shows `seg=100_0000`.
- Scan timing, handshake and `frame` behave identically in both builds.

## Test plan
All scenarios use PERIOD=4.
- **Reset, then idle for 16 cycles:**
  - Cycles 0–3: an=1110, seg=100_0000, frame=1 only on cycle 0.
  - Cycles 4–7, 8–11, 12–15: an=1101, 1011, 0111 respectively, all with seg=100_0000.
  - Cycle 16: frame=1 again.
- **Update 23 to slot 0 at cycle 5:**
  - upd_rdy=1 at cycle 5; digits 0–3 still show 0 for the rest of that frame.
  - From cycle 16: d=0 shows 011_0000 and d=1 shows 010_0100.
- **Back-to-back updates 9 then 31 to slot 1 at cycles 2 and 3:**
  - upd_rdy=0 at cycle 3; the second update is held until the boundary cycle 15 and accepted at cycle 16.
  - Frame 2 shows `act1`=9 (d=2: 001_1000).
  - Frame 3 shows 31 (d=2: 111_1001, d=3: 011_0000).
- **Update 17 to slot 0 exactly at boundary cycle 15 with pend clear:**
  - Cycle 16: d=0 shows 111_1000 and d=1 shows 111_1001.
  - upd_rdy stays 1.
- **Load 30 into slot 1, then assert reset at cycle 21 (mid-frame):**
  - Cycle 22: an=1110, seg=100_0000, `act1`=0, pend=00.
- **With `DISPLAY_SCAN_LZS_EN`, slot 1 = 7:**
  - d=3: an=1111, seg=111_1111.
  - d=2: seg=111_1000.
  - Without the macro, d=3 shows an=0111, seg=100_0000.

Source files
------------

// File: rtl/display_scan_ctrl_if.sv
// Update port bundle for display_scan_ctrl.
// Carries a valid/ready request that writes one of two display slots.
interface display_scan_ctrl_if;
  logic       val;
  logic       sel;
  logic [4:0] data;
  logic       rdy;

  modport master (
    output val,
    output sel,
    output data,
    input  rdy
  );

  modport slave (
    input  val,
    input  sel,
    input  data,
    output rdy
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// 4-digit multiplexed 7-segment scanner with frame-aligned value updates.
// Define DISPLAY_SCAN_LZS_EN to blank leading-zero tens digits.
module display_scan_ctrl #(
  parameter int PERIOD = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  display_scan_ctrl_if.slave   upd,
  output logic [6:0]           seg,
  output logic [3:0]           an,
  output logic                 frame
);

  localparam int PW = $clog2(PERIOD);

  logic [PW-1:0] pc;
  logic [1:0]    d;
  logic [4:0]    act0;
  logic [4:0]    act1;
  logic [4:0]    shd0;
  logic [4:0]    shd1;
  logic [1:0]    pend;

  logic          pc_last;
  logic          boundary;
  logic          xfer0;
  logic          xfer1;
  logic [13:0]   gl0;
  logic [13:0]   gl1;

  function automatic logic [6:0] enc(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b100_0000;
      4'd1:    s = 7'b111_1001;
      4'd2:    s = 7'b010_0100;
      4'd3:    s = 7'b011_0000;
      4'd4:    s = 7'b001_1001;
      4'd5:    s = 7'b001_0010;
      4'd6:    s = 7'b000_0010;
      4'd7:    s = 7'b111_1000;
      4'd8:    s = 7'b000_0000;
      4'd9:    s = 7'b001_1000;
      default: s = 7'b111_1111;
    endcase
    return s;
  endfunction

  // Binary 0..31 to {tens, ones} segment patterns.
  function automatic logic [13:0] display_gl(input logic [4:0] v);
    logic [3:0] tn;
    logic [3:0] on;
    if (v >= 5'd30) begin
      tn = 4'd3;
      on = 4'(v - 5'd30);
    end else if (v >= 5'd20) begin
      tn = 4'd2;
      on = 4'(v - 5'd20);
    end else if (v >= 5'd10) begin
      tn = 4'd1;
      on = 4'(v - 5'd10);
    end else begin
      tn = 4'd0;
      on = v[3:0];
    end
    return {enc(tn), enc(on)};
  endfunction

  assign pc_last  = (pc == PW'(PERIOD - 1));
  assign boundary = pc_last && (d == 2'd3);
  assign upd.rdy  = !pend[upd.sel];
  assign xfer0    = upd.val && upd.rdy && !upd.sel;
  assign xfer1    = upd.val && upd.rdy && upd.sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc   <= '0;
      d    <= 2'd0;
      act0 <= 5'd0;
      act1 <= 5'd0;
      shd0 <= 5'd0;
      shd1 <= 5'd0;
      pend <= 2'b00;
    end else begin
      pc <= pc_last ? '0 : pc + 1'b1;
      if (pc_last)
        d <= d + 2'd1;
      // A request landing on the boundary bypasses the shadow.
      if (boundary) begin
        if (xfer0)
          act0 <= upd.data;
        else if (pend[0])
          act0 <= shd0;
        if (xfer1)
          act1 <= upd.data;
        else if (pend[1])
          act1 <= shd1;
        pend <= 2'b00;
      end else begin
        if (xfer0) begin
          shd0    <= upd.data;
          pend[0] <= 1'b1;
        end
        if (xfer1) begin
          shd1    <= upd.data;
          pend[1] <= 1'b1;
        end
      end
    end
  end

  assign gl0 = display_gl(act0);
  assign gl1 = display_gl(act1);

  always_comb begin
    an  = 4'b1111;
    seg = 7'b111_1111;
    unique case (d)
      2'd0: begin
        an  = 4'b1110;
        seg = gl0[6:0];
      end
      2'd1: begin
`ifdef DISPLAY_SCAN_LZS_EN
        if (act0 >= 5'd10) begin
          an  = 4'b1101;
          seg = gl0[13:7];
        end
`else
        an  = 4'b1101;
        seg = gl0[13:7];
`endif
      end
      2'd2: begin
        an  = 4'b1011;
        seg = gl1[6:0];
      end
      2'd3: begin
`ifdef DISPLAY_SCAN_LZS_EN
        if (act1 >= 5'd10) begin
          an  = 4'b0111;
          seg = gl1[13:7];
        end
`else
        an  = 4'b0111;
        seg = gl1[13:7];
`endif
      end
    endcase
  end

  assign frame = (d == 2'd0) && (pc == '0);

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl at PERIOD=4.
// Stimulus queues expected outputs per cycle; a negedge monitor checks them.
module tb_display_scan_ctrl;

  logic       clk;
  logic       reset;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame;

  display_scan_ctrl_if u_if ();

  display_scan_ctrl #(.PERIOD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .upd   (u_if),
    .seg   (seg),
    .an    (an),
    .frame (frame)
  );

  typedef struct {
    int         cyc;
    string      name;
    bit         ck_disp;
    logic [3:0] an;
    logic [6:0] seg;
    bit         ck_frame;
    logic       frame;
    bit         ck_rdy;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   acyc = 0;
  int   base = 0;
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) acyc <= acyc + 1;

  task automatic exp_disp(input int k, input string nm,
                          input logic [3:0] a, input logic [6:0] s);
    exp_t e;
    e = '{cyc: base + k, name: nm, ck_disp: 1'b1, an: a, seg: s,
          ck_frame: 1'b0, frame: 1'b0, ck_rdy: 1'b0, rdy: 1'b0};
    q.push_back(e);
  endtask

  task automatic exp_frame(input int k, input string nm, input logic f);
    exp_t e;
    e = '{cyc: base + k, name: nm, ck_disp: 1'b0, an: 4'h0, seg: 7'h0,
          ck_frame: 1'b1, frame: f, ck_rdy: 1'b0, rdy: 1'b0};
    q.push_back(e);
  endtask

  task automatic exp_rdy(input int k, input string nm, input logic r);
    exp_t e;
    e = '{cyc: base + k, name: nm, ck_disp: 1'b0, an: 4'h0, seg: 7'h0,
          ck_frame: 1'b0, frame: 1'b0, ck_rdy: 1'b1, rdy: r};
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == acyc) begin
        if (q[i].ck_disp) begin
          checks++;
          if (an !== q[i].an || seg !== q[i].seg) begin
            errors++;
            $display("FAIL %s: an=%b seg=%b, expected an=%b seg=%b",
                     q[i].name, an, seg, q[i].an, q[i].seg);
          end
        end
        if (q[i].ck_frame) begin
          checks++;
          if (frame !== q[i].frame) begin
            errors++;
            $display("FAIL %s: frame=%b, expected %b",
                     q[i].name, frame, q[i].frame);
          end
        end
        if (q[i].ck_rdy) begin
          checks++;
          if (u_if.rdy !== q[i].rdy) begin
            errors++;
            $display("FAIL %s: upd_rdy=%b, expected %b",
                     q[i].name, u_if.rdy, q[i].rdy);
          end
        end
        q.delete(i);
      end else if (q[i].cyc < acyc) begin
        checks++;
        errors++;
        $display("FAIL %s: cycle %0d was never sampled", q[i].name, q[i].cyc);
        q.delete(i);
      end
    end
  end

  task automatic goto(input int k);
    int lim;
    lim = 0;
    while (acyc < base + k && lim < 2000) begin
      @(posedge clk);
      #1;
      lim++;
    end
    if (acyc != base + k) begin
      checks++;
      errors++;
      $display("FAIL goto: at cycle %0d, expected %0d", acyc, base + k);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset      = 1'b1;
    u_if.val   = 1'b0;
    u_if.sel   = 1'b0;
    u_if.data  = 5'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    base  = acyc;
  endtask

  task automatic drive(input logic v, input logic s, input logic [4:0] dt);
    u_if.val  = v;
    u_if.sel  = s;
    u_if.data = dt;
  endtask

  initial begin
    reset     = 1'b1;
    u_if.val  = 1'b0;
    u_if.sel  = 1'b0;
    u_if.data = 5'd0;

    // Idle scan after reset.
    do_reset();
    exp_rdy(0, "rst_rdy", 1'b1);
    for (int k = 0; k <= 16; k++) begin
      logic [3:0] a;
      case ((k / 4) % 4)
        0:       a = 4'b1110;
        1:       a = 4'b1101;
        2:       a = 4'b1011;
        default: a = 4'b0111;
      endcase
      exp_disp(k, $sformatf("idle_disp_c%0d", k), a, 7'b100_0000);
      exp_frame(k, $sformatf("idle_frame_c%0d", k), (k % 16) == 0);
    end
    goto(17);

    // 23 into slot 0 mid-frame.
    do_reset();
    exp_rdy(5, "u23_rdy", 1'b1);
    exp_disp(8, "u23_old_d2", 4'b1011, 7'b100_0000);
    exp_disp(12, "u23_old_d3", 4'b0111, 7'b100_0000);
    exp_disp(15, "u23_old_c15", 4'b0111, 7'b100_0000);
    exp_disp(16, "u23_ones", 4'b1110, 7'b011_0000);
    exp_frame(16, "u23_frame", 1'b1);
    exp_disp(20, "u23_tens", 4'b1101, 7'b010_0100);
    exp_disp(24, "u23_slot1", 4'b1011, 7'b100_0000);
    goto(5);
    drive(1'b1, 1'b0, 5'd23);
    goto(6);
    drive(1'b0, 1'b0, 5'd0);
    goto(25);

    // Back-to-back 9 then 31 into slot 1.
    do_reset();
    exp_rdy(2, "b2b_rdy_c2", 1'b1);
    exp_rdy(3, "b2b_rdy_c3", 1'b0);
    exp_rdy(15, "b2b_rdy_c15", 1'b0);
    exp_rdy(16, "b2b_rdy_c16", 1'b1);
    exp_rdy(17, "b2b_rdy_c17", 1'b0);
    exp_disp(8, "b2b_f1_d2", 4'b1011, 7'b100_0000);
    exp_disp(24, "b2b_f2_d2", 4'b1011, 7'b001_1000);
    exp_disp(28, "b2b_f2_d3", 4'b0111, 7'b100_0000);
    exp_disp(40, "b2b_f3_d2", 4'b1011, 7'b111_1001);
    exp_disp(44, "b2b_f3_d3", 4'b0111, 7'b011_0000);
    goto(2);
    drive(1'b1, 1'b1, 5'd9);
    goto(3);
    drive(1'b1, 1'b1, 5'd31);
    goto(17);
    u_if.val = 1'b0;
    goto(45);

    // 17 into slot 0 on the boundary cycle.
    do_reset();
    exp_rdy(15, "bnd_rdy_c15", 1'b1);
    exp_rdy(16, "bnd_rdy_c16", 1'b1);
    exp_disp(16, "bnd_ones", 4'b1110, 7'b111_1000);
    exp_frame(16, "bnd_frame", 1'b1);
    exp_disp(20, "bnd_tens", 4'b1101, 7'b111_1001);
    goto(15);
    drive(1'b1, 1'b0, 5'd17);
    goto(16);
    u_if.val = 1'b0;
    goto(21);

    // Reset in the middle of frame 2 with an update pending.
    do_reset();
    exp_disp(16, "mid_pre_d0", 4'b1110, 7'b100_0000);
    exp_rdy(19, "mid_pend_rdy", 1'b0);
    goto(1);
    drive(1'b1, 1'b1, 5'd30);
    goto(2);
    u_if.val = 1'b0;
    goto(18);
    drive(1'b1, 1'b1, 5'd5);
    goto(19);
    u_if.val = 1'b0;
    goto(21);
    reset = 1'b1;
    goto(22);
    reset = 1'b0;
    base  = acyc;
    exp_disp(0, "mid_rst_disp", 4'b1110, 7'b100_0000);
    exp_frame(0, "mid_rst_frame", 1'b1);
    exp_rdy(0, "mid_rst_rdy", 1'b1);
    exp_disp(8, "mid_act1_zero", 4'b1011, 7'b100_0000);
    exp_disp(24, "mid_pend_gone", 4'b1011, 7'b100_0000);
    goto(25);

    // Slot 1 = 7: tens blanked only with leading-zero suppression.
    do_reset();
    goto(1);
    drive(1'b1, 1'b1, 5'd7);
    goto(2);
    u_if.val = 1'b0;
    exp_disp(24, "lzs_d2", 4'b1011, 7'b111_1000);
    exp_frame(28, "lzs_frame_c28", 1'b0);
    exp_frame(32, "lzs_frame_c32", 1'b1);
`ifdef DISPLAY_SCAN_LZS_EN
    exp_disp(20, "lzs_d1", 4'b1111, 7'b111_1111);
    exp_disp(28, "lzs_d3", 4'b1111, 7'b111_1111);
`else
    exp_disp(20, "lzs_d1", 4'b1101, 7'b100_0000);
    exp_disp(28, "lzs_d3", 4'b0111, 7'b100_0000);
`endif
    goto(33);

    repeat (2) @(posedge clk);
    #1;
    while (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: cycle %0d left unchecked", q[0].name, q[0].cyc);
      void'(q.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
